// File: rtl/booth2_mul_arbiter.sv
// Round-robin arbiter sharing one iterative radix-4 Booth signed multiplier between NREQ requesters.
// Optional BOOTH_ZERO_SKIP_EN: zero operands skip the iteration phase and return 0 directly.

module booth2_pp #(
  parameter int W2 = 8
) (
  input  logic [2:0]    trip,
  input  logic [W2-1:0] xs,
  output logic [W2-1:0] pp
);
  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = xs;
      3'b011:         pp = xs << 1;
      3'b100:         pp = -(xs << 1);
      3'b101, 3'b110: pp = -xs;
      default:        pp = '0;
    endcase
  end
endmodule

module booth2_mul_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_multiplier,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*WIDTH-1:0]      result,
  output logic [IDW-1:0]          res_id,
  output logic                    busy
);
  localparam int PW   = 2 * WIDTH;
  localparam int ITER = WIDTH / 2;
  localparam int KW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                   state;
  logic [IDW-1:0]               ptr, cur_id, gnt_id;
  logic                         gnt_found, zero_op;
  logic [NREQ-1:0]              gnt_oh;
  logic [NREQ-1:0][WIDTH-1:0]   x_lane, m_lane;
  logic [PW-1:0]                xs, acc, pp;
  logic [WIDTH:0]               msh;
  logic [KW-1:0]                k;

  assign x_lane = req_x;
  assign m_lane = req_multiplier;

  // Scan from ptr upward, wrapping; first asserted request wins.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_found && req_valid[IDW'(j)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(j);
      end
    end
    if (gnt_found) gnt_oh[gnt_id] = 1'b1;
  end

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (x_lane[gnt_id] == '0) || (m_lane[gnt_id] == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign req_ready = (state == S_IDLE && !rst) ? gnt_oh : '0;
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // msh carries the implicit m[-1]=0 in bit 0, so bits [2:0] are always the current triplet.
  booth2_pp #(.W2(PW)) u_pp (
    .trip (msh[2:0]),
    .xs   (xs),
    .pp   (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      cur_id <= '0;
      res_id <= '0;
      result <= '0;
      acc    <= '0;
      xs     <= '0;
      msh    <= '0;
      k      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            cur_id <= gnt_id;
            ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            xs     <= {{WIDTH{x_lane[gnt_id][WIDTH-1]}}, x_lane[gnt_id]};
            msh    <= {m_lane[gnt_id], 1'b0};
            acc    <= '0;
            k      <= '0;
            if (zero_op) begin
              result <= '0;
              res_id <= gnt_id;
              state  <= S_DONE;
            end else begin
              state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc <= acc + pp;
          xs  <= xs << 2;
          msh <= msh >> 2;
          k   <= k + KW'(1);
          if (k == KW'(ITER - 1)) begin
            result <= acc + pp;
            res_id <= cur_id;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth2_mul_arbiter.sv
// Directed bench for booth2_mul_arbiter: scoreboard of expected products, immediate-assertion checks.

module tb_booth2_mul_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 3;
`endif

  typedef struct {
    logic [0:0] id;
    logic [7:0] res;
  } exp_t;

  logic                  clk, rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_x, req_multiplier;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid, res_ready;
  logic [2*WIDTH-1:0]    result;
  logic [0:0]            res_id;
  logic                  busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  booth2_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_x          (req_x),
    .req_multiplier (req_multiplier),
    .req_ready      (req_ready),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .result         (result),
    .res_id         (res_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] prod(input logic [3:0] x, input logic [3:0] m);
    logic signed [7:0] xe, me;
    xe = {{4{x[3]}}, x};
    me = {{4{m[3]}}, m};
    return 8'(xe * me);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for any grant, evaluated just after the current negedge.
  task automatic wait_grant();
    int n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic push(input int id, input logic [3:0] x, input logic [3:0] m);
    exp_t e;
    e.id  = 1'(id);
    e.res = prod(x, m);
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input logic [3:0] x, input logic [3:0] m);
    req_x[id*4 +: 4]          = x;
    req_multiplier[id*4 +: 4] = m;
    req_valid[id]             = 1'b1;
    wait_grant();
    chk("grant", 32'(req_ready), 32'd1 << id);
    push(id, x, m);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("ready_pulse", 32'(req_ready), 32'd0);
  endtask

  // Called at the negedge after the accepting edge; that edge counts as latency 1.
  task automatic collect(input int exp_lat, input int stall);
    int   lat = 1;
    exp_t e;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty expected entry");
      e.id = '0; e.res = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("result", 32'(result), 32'(e.res));
    chk("res_id", 32'(res_id), 32'(e.id));
    chk("ready_in_done", 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_result", 32'(result), 32'(e.res));
      chk("stall_id", 32'(res_id), 32'(e.id));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    req_x          = '0;
    req_multiplier = '0;
    res_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Both requesters valid continuously: grants alternate starting at 0.
    req_x          = {4'b0011, 4'b0101};
    req_multiplier = {4'b1110, 4'b0110};
    req_valid      = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant();
      chk("rr_grant", 32'(req_ready), 32'd1 << (g % 2));
      push(g % 2, req_x[(g % 2)*4 +: 4], req_multiplier[(g % 2)*4 +: 4]);
      @(posedge clk);
      @(negedge clk);
      chk("rr_pulse", 32'(req_ready), 32'd0);
      collect(3, 0);
    end
    req_valid = '0;

    // Single-requester products, including most-negative squared.
    issue(0, 4'b1011, 4'b1001);
    collect(3, 0);
    issue(1, 4'b0110, 4'b1101);
    collect(3, 0);
    issue(1, 4'b1100, 4'b1111);
    collect(3, 0);
    issue(1, 4'b1000, 4'b1000);
    collect(3, 0);
    issue(0, 4'b0111, 4'b1000);
    collect(3, 0);

    // Backpressure: result held while a competing request waits.
    res_ready = 1'b0;
    issue(0, 4'b0011, 4'b0101);
    req_x[7:4]          = 4'b0010;
    req_multiplier[7:4] = 4'b0011;
    req_valid[1]        = 1'b1;
    collect(3, 5);
    chk("post_stall_grant", 32'(req_ready), 32'd2);
    push(1, 4'b0010, 4'b0011);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect(3, 0);

    // Zero operands.
    issue(0, 4'b0000, 4'b0111);
    collect(ZLAT, 0);
    issue(1, 4'b0101, 4'b0000);
    collect(ZLAT, 0);

    // Reset in BUSY aborts the operation and restores priority to requester 0.
    issue(1, 4'b0101, 4'b0011);
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_res_id", 32'(res_id), 32'd0);
    chk("abort_busy_clr", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(res_valid), 32'd0);
    end
    req_x[7:4]          = 4'b0001;
    req_multiplier[7:4] = 4'b0001;
    req_valid[1]        = 1'b1;
    issue(0, 4'b1101, 4'b0111);
    req_valid[1] = 1'b0;
    collect(3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
